// File: rtl/bcd_conv_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_conv_arbiter
// Two-requester arbiter in front of a shared binary-to-BCD converter. It
// accepts one signed 16-bit operand at a time. The magnitude is converted with
// a 16-step double-dabble shift, and the result comes out as 5 packed BCD
// digits plus a sign bit.
//
// Parameters
//   RR       1 = round-robin between requesters, 0 = fixed priority (req[0])
// Ports
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   req      per-requester conversion request, held until granted
//   bin0     requester 0 operand (two's complement)
//   bin1     requester 1 operand (two's complement)
//   gnt      one-hot, one-cycle accept pulse
//   busy     high while a conversion is in flight (state != IDLE)
//   done     one-cycle result-valid pulse
//   done_id  requester index of the presented result
//   bcd      5 packed BCD digits of |operand|, [19:16] = ten-thousands
//   sign     1 when the operand was negative
// -----------------------------------------------------------------------------
module bcd_conv_arbiter #(
    parameter int unsigned RR = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic signed [15:0] bin0,
    input  logic signed [15:0] bin1,
    output logic [1:0]         gnt,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic [19:0]        bcd,
    output logic               sign
);

    localparam int unsigned OP_W   = 16;
    localparam int unsigned BCD_W  = 20;
    localparam int unsigned NDIG   = 5;
    localparam int unsigned WORK_W = OP_W + BCD_W;
    localparam int unsigned CNT_W  = 5;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OP_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e              state_q,   state_d;
    logic [WORK_W-1:0]   work_q,    work_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic                ptr_q,     ptr_d;
    logic                id_q,      id_d;
    logic                neg_q,     neg_d;
    logic [1:0]          gnt_q,     gnt_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                done_id_q, done_id_d;
    logic [BCD_W-1:0]    bcd_q,     bcd_d;
    logic                sign_q,    sign_d;

    logic                win_c;
    logic signed [OP_W-1:0] op_c;
    logic [OP_W-1:0]     mag_c;
    logic [WORK_W-1:0]   adj_c;

    // Winner select: on a tie, round-robin picks the requester not served last.
    always_comb begin
        win_c = 1'b0;
        if (req == 2'b11) begin
            win_c = (RR != 0) ? ~ptr_q : 1'b0;
        end else begin
            win_c = req[1];
        end
    end

    // Operand mux and magnitude; -32768 wraps to 16'h8000, which is 32768 unsigned.
    always_comb begin
        op_c  = win_c ? bin1 : bin0;
        mag_c = op_c[OP_W-1] ? OP_W'(-op_c) : OP_W'(op_c);
    end

    // Double-dabble correction: add 3 to every BCD nibble that is >= 5.
    always_comb begin
        adj_c = work_q;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (work_q[OP_W + 4*i +: 4] >= 4'd5) begin
                adj_c[OP_W + 4*i +: 4] = work_q[OP_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        neg_d     = neg_q;
        gnt_d     = 2'b00;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        bcd_d     = bcd_q;
        sign_d    = sign_q;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d = SHIFT;
                    gnt_d   = 2'(2'b01 << win_c);
                    id_d    = win_c;
                    ptr_d   = win_c;
                    neg_d   = op_c[OP_W-1];
                    work_d  = {{BCD_W{1'b0}}, mag_c};
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                work_d = {adj_c[WORK_W-2:0], 1'b0};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    bcd_d     = work_d[WORK_W-1:OP_W];
                    sign_d    = neg_q;
                    done_id_d = id_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            ptr_q     <= 1'b1;
            id_q      <= 1'b0;
            neg_q     <= 1'b0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            bcd_q     <= '0;
            sign_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            neg_q     <= neg_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            bcd_q     <= bcd_d;
            sign_q    <= sign_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign bcd     = bcd_q;
    assign sign    = sign_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bcd_conv_arbiter
// Bench for bcd_conv_arbiter. It instantiates a round-robin copy (u_rr) and a
// fixed-priority copy (u_fp), and both copies share the same stimulus.
// Expected u_rr results are queued when stimulus is driven. They are popped and
// compared when u_rr pulses done.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd_conv_arbiter;

    typedef struct packed {
        logic        id;
        logic [19:0] bcd;
        logic        sign;
    } exp_t;

    logic               clk;
    logic               rst;
    logic [1:0]         req;
    logic signed [15:0] bin0;
    logic signed [15:0] bin1;

    logic [1:0]  gnt_r,  gnt_f;
    logic        busy_r, busy_f;
    logic        done_r, done_f;
    logic        id_r,   id_f;
    logic [19:0] bcd_r,  bcd_f;
    logic        sign_r, sign_f;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    bcd_conv_arbiter #(.RR(1)) u_rr (
        .clk(clk), .rst(rst), .req(req), .bin0(bin0), .bin1(bin1),
        .gnt(gnt_r), .busy(busy_r), .done(done_r), .done_id(id_r),
        .bcd(bcd_r), .sign(sign_r)
    );

    bcd_conv_arbiter #(.RR(0)) u_fp (
        .clk(clk), .rst(rst), .req(req), .bin0(bin0), .bin1(bin1),
        .gnt(gnt_f), .busy(busy_f), .done(done_f), .done_id(id_f),
        .bcd(bcd_f), .sign(sign_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input logic id, input logic [19:0] b, input logic s);
        exp_t e;
        e.id   = id;
        e.bcd  = b;
        e.sign = s;
        sb_q.push_back(e);
    endtask

    // Drive a request, drop it once granted, then wait for the result.
    task automatic do_req(input logic [1:0] r, input logic [1:0] g_exp, input string name);
        int n;
        bit seen;
        req  = r;
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (gnt_r !== 2'b00) seen = 1;
        end
        n_tests++;
        if (gnt_r !== g_exp) begin
            n_fail++;
            $display("FAIL %s_gnt: got %b, required %b", name, gnt_r, g_exp);
        end
        req  = 2'b00;
        n    = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done_r === 1'b1) seen = 1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_done_timeout: got no done in %0d cycles, required done", name, n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 2'b00;
        bin0 = '0;
        bin1 = '0;
        repeat (2) @(negedge clk);
        n_tests++; if (gnt_r !== 2'b00)  begin n_fail++; $display("FAIL reset_gnt: got %b, required 00", gnt_r); end
        n_tests++; if (busy_r !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy_r); end
        n_tests++; if (done_r !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b, required 0", done_r); end
        n_tests++; if (id_r !== 1'b0)    begin n_fail++; $display("FAIL reset_done_id: got %b, required 0", id_r); end
        n_tests++; if (bcd_r !== 20'h0)  begin n_fail++; $display("FAIL reset_bcd: got %h, required 00000", bcd_r); end
        n_tests++; if (sign_r !== 1'b0)  begin n_fail++; $display("FAIL reset_sign: got %b, required 0", sign_r); end
        n_tests++; if (busy_f !== 1'b0 || gnt_f !== 2'b00 || done_f !== 1'b0)
            begin n_fail++; $display("FAIL reset_fp: got busy=%b gnt=%b done=%b, required 0 00 0", busy_f, gnt_f, done_f); end
        rst = 1'b0;
    endtask

    // gnt appears one cycle after E0; done appears one cycle after E16, so it is 16 cycles after gnt.
    task automatic test_single();
        int n;
        bin0 = 16'sd1234;
        push_exp(1'b0, 20'h01234, 1'b0);
        req = 2'b01;
        @(negedge clk);
        n_tests++; if (gnt_r !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b, required 01", gnt_r); end
        req = 2'b00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                n_tests++; if (gnt_r !== 2'b00) begin n_fail++; $display("FAIL single_gnt_width: got %b, required 00", gnt_r); end
                n_tests++; if (busy_r !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b, required 1", busy_r); end
            end
        end while (done_r !== 1'b1 && n < 40);
        n_tests++; if (n != 16) begin n_fail++; $display("FAIL single_latency: got %0d, required 16", n); end
        @(negedge clk);
        n_tests++; if (done_r !== 1'b0 || busy_r !== 1'b0)
            begin n_fail++; $display("FAIL single_after_done: got done=%b busy=%b, required 0 0", done_r, busy_r); end
        n_tests++; if (bcd_r !== 20'h01234) begin n_fail++; $display("FAIL single_hold: got %h, required 01234", bcd_r); end
    endtask

    task automatic test_extremes();
        bin1 = 16'h8000;
        push_exp(1'b1, 20'h32768, 1'b1);
        do_req(2'b10, 2'b10, "neg_min");
        bin1 = 16'sd0;
        push_exp(1'b1, 20'h00000, 1'b0);
        do_req(2'b10, 2'b10, "zero");
        n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL extremes_sb_left: got %0d, required 0", sb_q.size()); end
    endtask

    task automatic test_rr_tie();
        int d[3];
        int k;
        int n;
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        bin0 = -16'sd1;
        bin1 = 16'sd9999;
        push_exp(1'b0, 20'h00001, 1'b1);
        push_exp(1'b1, 20'h09999, 1'b0);
        push_exp(1'b0, 20'h00001, 1'b1);
        req = 2'b11;
        k = 0;
        n = 0;
        while (k < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (done_r === 1'b1) begin d[k] = cyc; k++; end
        end
        req = 2'b00;
        n_tests++; if (k != 3) begin n_fail++; $display("FAIL rr_done_count: got %0d, required 3", k); end
        if (k == 3) begin
            n_tests++; if (d[1] - d[0] != 18) begin n_fail++; $display("FAIL rr_gap1: got %0d, required 18", d[1] - d[0]); end
            n_tests++; if (d[2] - d[1] != 18) begin n_fail++; $display("FAIL rr_gap2: got %0d, required 18", d[2] - d[1]); end
        end
        repeat (3) @(negedge clk);
        n_tests++; if (busy_r !== 1'b0) begin n_fail++; $display("FAIL rr_no_extra: got busy=%b, required 0", busy_r); end
        n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL rr_sb_left: got %0d, required 0", sb_q.size()); end
    endtask

    task automatic test_fixed_priority();
        int g0;
        int g1;
        int k;
        int n;
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        bin0 = 16'sd5;
        bin1 = 16'sd7;
        push_exp(1'b0, 20'h00005, 1'b0);
        push_exp(1'b1, 20'h00007, 1'b0);
        req = 2'b11;
        g0 = 0; g1 = 0; k = 0; n = 0;
        while (k < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (gnt_f[0] === 1'b1) g0++;
            if (gnt_f[1] === 1'b1) g1++;
            if (done_f === 1'b1) begin
                k++;
                n_tests++; if (id_f !== 1'b0 || bcd_f !== 20'h00005)
                    begin n_fail++; $display("FAIL fp_result: got id=%b bcd=%h, required 0 00005", id_f, bcd_f); end
            end
        end
        req = 2'b00;
        n_tests++; if (g0 != 2) begin n_fail++; $display("FAIL fp_gnt0: got %0d, required 2", g0); end
        n_tests++; if (g1 != 0) begin n_fail++; $display("FAIL fp_gnt1: got %0d, required 0", g1); end
        repeat (3) @(negedge clk);
        n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL fp_sb_left: got %0d, required 0", sb_q.size()); end
    endtask

    task automatic test_reset_abort();
        int n;
        bin0 = 16'sd4321;
        req  = 2'b01;
        @(negedge clk);
        n_tests++; if (gnt_r !== 2'b01) begin n_fail++; $display("FAIL abort_gnt: got %b, required 01", gnt_r); end
        req = 2'b00;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (busy_r !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", busy_r); end
        n_tests++; if (bcd_r !== 20'h0) begin n_fail++; $display("FAIL abort_bcd: got %h, required 00000", bcd_r); end
        n_tests++; if (done_r !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b, required 0", done_r); end
        rst = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_r === 1'b1) n++;
        end
        n_tests++; if (n != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses, required 0", n); end
        bin0 = 16'sd77;
        push_exp(1'b0, 20'h00077, 1'b0);
        do_req(2'b01, 2'b01, "after_abort");
        n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL abort_sb_left: got %0d, required 0", sb_q.size()); end
    endtask

    task automatic test_req_during_shift();
        int g;
        int dn;
        bin0 = 16'sd11;
        bin1 = 16'sd250;
        push_exp(1'b0, 20'h00011, 1'b0);
        push_exp(1'b1, 20'h00250, 1'b0);
        req = 2'b01;
        @(negedge clk);
        n_tests++; if (gnt_r !== 2'b01) begin n_fail++; $display("FAIL shift_first_gnt: got %b, required 01", gnt_r); end
        g  = 0;
        dn = 0;
        for (int i = 1; i <= 17; i++) begin
            if (i < 13) req = (i % 3 == 0) ? 2'b10 : ((i % 3 == 1) ? 2'b11 : 2'b00);
            else        req = 2'b10;
            @(negedge clk);
            if (gnt_r !== 2'b00) g++;
            if (done_r === 1'b1) dn++;
        end
        n_tests++; if (g != 0)  begin n_fail++; $display("FAIL shift_no_gnt: got %0d grants, required 0", g); end
        n_tests++; if (dn != 1) begin n_fail++; $display("FAIL shift_done_count: got %0d, required 1", dn); end
        @(negedge clk);
        n_tests++; if (gnt_r !== 2'b10) begin n_fail++; $display("FAIL shift_idle_gnt: got %b, required 10", gnt_r); end
        req = 2'b00;
        dn = 0;
        for (int i = 0; i < 40 && dn == 0; i++) begin
            @(negedge clk);
            if (done_r === 1'b1) dn++;
        end
        n_tests++; if (dn != 1) begin n_fail++; $display("FAIL shift_second_done: got %0d, required 1", dn); end
        repeat (2) @(negedge clk);
        n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL shift_sb_left: got %0d, required 0", sb_q.size()); end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 2'b00;
        bin0 = '0;
        bin1 = '0;

        // Scoreboard and invariant monitor.
        fork
            forever begin
                @(negedge clk);
                if (rst !== 1'b1) begin
                    if (gnt_r !== 2'b00) begin
                        n_tests++;
                        if (gnt_r !== 2'b01 && gnt_r !== 2'b10) begin
                            n_fail++; $display("FAIL gnt_onehot_rr: got %b, required one-hot", gnt_r);
                        end
                        n_tests++;
                        if (done_r !== 1'b0) begin
                            n_fail++; $display("FAIL gnt_with_done_rr: got done=%b, required 0", done_r);
                        end
                    end
                    if (gnt_f !== 2'b00) begin
                        n_tests++;
                        if ((gnt_f !== 2'b01 && gnt_f !== 2'b10) || done_f !== 1'b0) begin
                            n_fail++; $display("FAIL gnt_fp: got gnt=%b done=%b, required one-hot and done 0", gnt_f, done_f);
                        end
                    end
                    if (done_r === 1'b1) begin
                        n_tests++;
                        if (sb_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL sb_unexpected_done: got id=%b bcd=%h sign=%b, required no done", id_r, bcd_r, sign_r);
                        end else begin
                            mon_e = sb_q.pop_front();
                            if (id_r !== mon_e.id || bcd_r !== mon_e.bcd || sign_r !== mon_e.sign) begin
                                n_fail++;
                                $display("FAIL sb_result: got id=%b bcd=%h sign=%b, required id=%b bcd=%h sign=%b",
                                         id_r, bcd_r, sign_r, mon_e.id, mon_e.bcd, mon_e.sign);
                            end
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_single();
        test_extremes();
        test_rr_tie();
        test_fixed_priority();
        test_reset_abort();
        test_req_during_shift();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
